// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment scanner.
package sevseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam int   IDX_W_MAX = 3;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sevseg_if.sv
// Digit data/control in, segment and anode drive out.
interface sevseg_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    load;
    logic [3:0]              brightness;
    logic [6:0]              cathode_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   anode_out;
    logic                    frame_done;

    modport master (
        output data_in, dp_in, blank_in, load, brightness,
        input  cathode_out, dp_out, anode_out, frame_done
    );

    modport slave (
        input  data_in, dp_in, blank_in, load, brightness,
        output cathode_out, dp_out, anode_out, frame_done
    );
endinterface

// File: rtl/sevseg_decode.sv
// Hex nibble to active-low segments {A..G}; anything unrecognised stays dark.
module sevseg_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    always_comb begin
        case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0001100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sevseg_scan.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering and PWM.
// Define LEADING_ZERO_SUPPRESS_EN to blank leading zero digits.
module sevseg_scan
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic    CLK,
    input  logic    RESET,
    sevseg_if.slave bus
);

    localparam int IW = idx_width(NUM_DIGITS);

    logic [DIV_WIDTH-1:0]        cnt;
    logic [IW-1:0]               idx;
    logic                        pend_vld;
    logic [NUM_DIGITS-1:0][3:0]  pend_data, sh_data;
    logic [NUM_DIGITS-1:0]       pend_dp, pend_blank, sh_dp, sh_blank, supp;
    seg_t [NUM_DIGITS-1:0]       seg_arr;
    logic                        tick, last, boundary, pwm_on;
    logic [NUM_DIGITS-1:0]       an_n;
    seg_t                        cat_n;
    logic                        dp_n;

    assign tick     = &cnt;
    assign last     = (idx == IW'(NUM_DIGITS - 1));
    assign boundary = tick & last;
    assign pwm_on   = (cnt[DIV_WIDTH-1 -: 4] < bus.brightness) || (bus.brightness == 4'hF);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        sevseg_decode u_dec (.hex(sh_data[g]), .seg(seg_arr[g]));
    end

`ifdef LEADING_ZERO_SUPPRESS_EN
    // A digit is suppressed when it and every digit above it are zero.
    always_comb begin
        logic run;
        run  = 1'b1;
        supp = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run     = run & (sh_data[i] == 4'h0);
            supp[i] = run;
        end
    end
`else
    assign supp = '0;
`endif

    always_comb begin
        an_n  = '0;
        cat_n = SEG_BLANK;
        dp_n  = 1'b1;
        if (pwm_on && !sh_blank[idx]) begin
            if (!supp[idx]) begin
                an_n[idx] = 1'b1;
                cat_n     = seg_arr[idx];
                dp_n      = ~sh_dp[idx];
            end else if (sh_dp[idx]) begin
                an_n[idx] = 1'b1;
                dp_n      = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt             <= '0;
            idx             <= '0;
            pend_vld        <= 1'b0;
            pend_data       <= '0;
            pend_dp         <= '0;
            pend_blank      <= '0;
            sh_data         <= '0;
            sh_dp           <= '0;
            sh_blank        <= '1;
            bus.anode_out   <= '0;
            bus.cathode_out <= SEG_BLANK;
            bus.dp_out      <= 1'b1;
            bus.frame_done  <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (tick)
                idx <= last ? '0 : idx + 1'b1;
            bus.frame_done <= boundary;
            // Shadow only moves at the frame boundary, so a frame never tears.
            if (boundary) begin
                pend_vld <= 1'b0;
                if (bus.load) begin
                    sh_data  <= bus.data_in;
                    sh_dp    <= bus.dp_in;
                    sh_blank <= bus.blank_in;
                end else if (pend_vld) begin
                    sh_data  <= pend_data;
                    sh_dp    <= pend_dp;
                    sh_blank <= pend_blank;
                end
            end else if (bus.load) begin
                pend_data  <= bus.data_in;
                pend_dp    <= bus.dp_in;
                pend_blank <= bus.blank_in;
                pend_vld   <= 1'b1;
            end
            bus.anode_out   <= an_n;
            bus.cathode_out <= cat_n;
            bus.dp_out      <= dp_n;
        end
    end

endmodule

// File: tb/tb_sevseg_scan.sv
// Scoreboard bench for sevseg_scan (NUM_DIGITS=4, DIV_WIDTH=4); model tracks frame position arithmetically.
module tb_sevseg_scan;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int DIGIT_CYC = 1 << DW;
    localparam int FRAME_CYC = DIGIT_CYC * ND;

    typedef struct packed {
        logic [ND-1:0] an;
        logic [6:0]    cat;
        logic          dp;
        logic          fd;
    } exp_t;

    localparam logic [6:0] HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic CLK;
    logic RESET;
    sevseg_if #(.NUM_DIGITS(ND)) bus ();

    sevseg_scan #(.NUM_DIGITS(ND), .DIV_WIDTH(DW)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    // reference model state: position within frame plus pending/shadow contents
    int            mt;
    bit            m_pv;
    logic [15:0]   m_pd, m_sd;
    logic [ND-1:0] m_pdp, m_pbl, m_sdp, m_sbl;

    task automatic model_reset();
        mt = 0; m_pv = 0; m_pd = '0; m_sd = '0;
        m_pdp = '0; m_pbl = '0; m_sdp = '0; m_sbl = '1;
    endtask

    task automatic cyc();
        exp_t e;
        int   c, d;
        bit   bnd, on, sup;
        e = '{an: '0, cat: 7'h7F, dp: 1'b1, fd: 1'b0};
        if (RESET) begin
            model_reset();
        end else begin
            c   = mt % DIGIT_CYC;
            d   = mt / DIGIT_CYC;
            bnd = (mt == FRAME_CYC - 1);
            e.fd = bnd;
            on  = (bus.brightness == 4'd15) || ((c >> (DW - 4)) < int'(bus.brightness));
            sup = 0;
`ifdef LEADING_ZERO_SUPPRESS_EN
            sup = (d > 0) && ((m_sd >> (4 * d)) == 16'h0);
`endif
            if (on && !m_sbl[d]) begin
                if (!sup) begin
                    e.an  = ND'(1 << d);
                    e.cat = HEX[m_sd[4*d +: 4]];
                    e.dp  = ~m_sdp[d];
                end else if (m_sdp[d]) begin
                    e.an = ND'(1 << d);
                    e.dp = 1'b0;
                end
            end
            if (bnd) begin
                if (bus.load) begin
                    m_sd = bus.data_in; m_sdp = bus.dp_in; m_sbl = bus.blank_in;
                end else if (m_pv) begin
                    m_sd = m_pd; m_sdp = m_pdp; m_sbl = m_pbl;
                end
                m_pv = 0;
            end else if (bus.load) begin
                m_pd = bus.data_in; m_pdp = bus.dp_in; m_pbl = bus.blank_in; m_pv = 1;
            end
            mt = (mt + 1) % FRAME_CYC;
        end
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic to_mt(input int target);
        for (int i = 0; i < FRAME_CYC && mt != target; i++) cyc();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [ND-1:0] dp, input logic [ND-1:0] bl);
        bus.data_in  = d;
        bus.dp_in    = dp;
        bus.blank_in = bl;
        bus.load     = 1'b1;
        cyc();
        bus.load     = 1'b0;
    endtask

    // monitor: every cycle presents one registered output word
    initial begin
        exp_t e, a;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{an: bus.anode_out, cat: bus.cathode_out, dp: bus.dp_out, fd: bus.frame_done};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s t=%0t got an=%b cat=%b dp=%b fd=%b, expected an=%b cat=%b dp=%b fd=%b",
                             phase, $time, a.an, a.cat, a.dp, a.fd, e.an, e.cat, e.dp, e.fd);
                end
            end
        end
    end

    initial begin
        model_reset();
        RESET          = 1'b1;
        bus.data_in    = '0;
        bus.dp_in      = '0;
        bus.blank_in   = '0;
        bus.load       = 1'b0;
        bus.brightness = 4'd15;

        phase = "reset";
        run(3);
        RESET = 1'b0;

        phase = "basic";
        do_load(16'h12AF, 4'b0000, 4'b0000);
        to_mt(FRAME_CYC - 1);
        run(2 * FRAME_CYC + 1);

        phase = "midframe";
        to_mt(20);
        do_load(16'h3333, 4'b0010, 4'b0000);
        to_mt(FRAME_CYC - 1);
        run(FRAME_CYC);
        phase = "bypass";
        do_load(16'h4321, 4'b0101, 4'b0000);
        run(FRAME_CYC + 1);

        phase = "pwm0";
        bus.brightness = 4'd0;
        run(FRAME_CYC);
        phase = "pwm4";
        bus.brightness = 4'd4;
        run(FRAME_CYC);
        bus.brightness = 4'd15;

        phase = "zeros";
        to_mt(10);
        do_load(16'h0005, 4'b0100, 4'b0000);
        to_mt(FRAME_CYC - 1);
        run(FRAME_CYC + 1);

        phase = "rst_mid";
        to_mt(2 * DIGIT_CYC + 3);
        do_load(16'hBEEF, 4'b1111, 4'b0000);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        run(2 * FRAME_CYC + 2);

        phase = "random";
        for (int i = 0; i < 900; i++) begin
            bus.load = ($urandom_range(0, 7) == 0);
            if (bus.load) begin
                bus.data_in  = 16'($urandom);
                bus.dp_in    = ND'($urandom);
                bus.blank_in = ($urandom_range(0, 3) == 0) ? ND'($urandom) : '0;
                if ($urandom_range(0, 3) == 0) bus.data_in = 16'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 31) == 0) bus.brightness = 4'($urandom);
            RESET = ($urandom_range(0, 199) == 0);
            cyc();
        end
        RESET    = 1'b0;
        bus.load = 1'b0;

        @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending entries, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevseg_scan.md
SEVSEG_SCAN -- requirements
Module: sevseg_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning digit count (legal 2..8).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, meaning prescale counter width (legal 4..24).
REQ-003 SHALL have port CLK  input  1  clock.
REQ-004 SHALL have port RESET  input  1  reset: synchronous, active-high, sampled on CLK.
REQ-005 SHALL have port data_in  input  4*NUM_DIGITS  hex nibbles; digit 0 = bits [3:0], rightmost.
REQ-006 SHALL have port dp_in  input  NUM_DIGITS  decimal-point request per digit (1 = lit).
REQ-007 SHALL have port blank_in  input  NUM_DIGITS  per-digit force-blank (1 = dark).
REQ-008 SHALL have port load  input  1  capture strobe for data_in/dp_in/blank_in.
REQ-009 SHALL have port brightness  input  4  PWM duty, 0 = off, 15 = full.
REQ-010 SHALL have port cathode_out  output  7  segments {A,B,C,D,E,F,G} as bits [6:0], active-low.
REQ-011 SHALL have port dp_out  output  1  decimal point, active-low.
REQ-012 SHALL have port anode_out  output  NUM_DIGITS  one-hot digit enable, active-high.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 Prescale counter SHALL increment every cycle and wrap at all-ones; tick = counter all-ones.
REQ-015 On tick, digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-016 Frame boundary SHALL be tick with index NUM_DIGITS-1; frame_done SHALL assert the cycle after that boundary, for exactly one cycle.
REQ-017 load SHALL copy inputs into pending registers and set pending flag; later load before boundary SHALL overwrite pending.
REQ-018 At frame boundary with pending set, pending SHALL transfer to display shadow and pending SHALL clear; without pending, shadow SHALL hold.
REQ-019 load coincident with boundary SHALL bypass: that cycle's inputs go directly to shadow, pending clears.
REQ-020 Displayed digit SHALL come only from shadow; shadow SHALL never change mid-frame (no tearing).
REQ-021 Hex mapping SHALL be 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111 8:0000000 9:0001100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000.
REQ-022 PWM on-window: counter[DIV_WIDTH-1 -: 4] < brightness, or brightness == 15 (always on).
REQ-023 When on-window true and digit not blanked, anode_out SHALL be one-hot at index; otherwise anode_out SHALL be 0, cathode_out 7'h7F, dp_out 1.
REQ-024 cathode_out, dp_out, anode_out SHALL be registered: one-cycle latency from counter/index to pins.
REQ-025 brightness SHALL be sampled live (no shadowing); change takes effect next cycle.

Reset
REQ-026 RESET SHALL zero counter, index, pending flag, pending and shadow data; shadow blank SHALL reset all-ones.
REQ-027 During and first cycle after RESET: anode_out 0, cathode_out 7'h7F, dp_out 1, frame_done 0.
REQ-028 RESET mid-frame SHALL discard pending load and restart scan at digit 0.

Configuration
REQ-029 With LEADING_ZERO_SUPPRESS_EN defined, zero shadow digits above the highest nonzero digit SHALL be blanked; digit 0 never suppressed; dp_in of a suppressed digit still SHALL light dp only.
REQ-030 Without LEADING_ZERO_SUPPRESS_EN, zero digits SHALL display as 0000001.

Structure
REQ-031 Package sevseg_pkg SHALL hold seg_t (7-bit), SEG_BLANK = 7'h7F, and index-width helper constant.
REQ-032 Hex-to-segment mapping SHALL be sub-module sevseg_decode (combinational, 4-bit in, seg_t out); unknown input -> SEG_BLANK.

Verification (NUM_DIGITS=4, DIV_WIDTH=4)
REQ-033 RESET 3 cycles -> anode_out 4'b0000, cathode_out 7'h7F, dp_out 1, frame_done 0.
REQ-034 load 16'h12AF, brightness 15, wait boundary -> anode 0001/0010/0100/1000, 16 cycles each; cathode 0111000, 0001000, 0010010, 1001111; frame_done every 64 cycles.
REQ-035 load 16'h3333 mid-frame -> 16'h12AF persists until boundary; new value from next frame; load on boundary cycle -> bypass, shown next frame.
REQ-036 brightness 0 -> anode_out 0 always; brightness 4 -> anode on 4 of 16 cycles per digit.
REQ-037 data 16'h0005, blank_in 0: macro defined -> digits 3..1 dark, digit 0 0100100; undefined -> digits 3..1 0000001.
REQ-038 RESET asserted at digit 2 with pending load -> scan restarts digit 0, dark shadow, pending lost.
